// File: rtl/vga_pixel_capture.sv
// Purpose: rebuilds 24-bit pixels from the 2x-rate half-pixel bus, half phase aligned to hsync.
// Latency: B half sampled at the pins on edge k -> pixel_valid/pixel_data after edge k+2.
// Backpressure: none; free-running capture, a pixel is emitted every 2nd cycle while locked.
// Ports: pixel_clk_2x/reset_n clock and async active-low reset; hsync/vsync/vga_in capture
//        inputs; err_clr clears phase_err; pixel_data/pixel_valid/x_count/y_count pixel stream;
//        frame_start vsync pulse; locked/phase_err alignment status.
module vga_pixel_capture #(
    parameter int SKEW       = 1,
    parameter int LOCK_LINES = 4,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10
) (
    input  logic              pixel_clk_2x,
    input  logic              reset_n,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [11:0]       vga_in,
    input  logic              err_clr,
    output logic [23:0]       pixel_data,
    output logic              pixel_valid,
    output logic [X_BITS-1:0] x_count,
    output logic [Y_BITS-1:0] y_count,
    output logic              frame_start,
    output logic              locked,
    output logic              phase_err
);
    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

    localparam logic [1:0]        SKEW_LD = (SKEW > 0) ? 2'(SKEW - 1) : 2'd0;
    localparam logic [3:0]        LOCK_N  = 4'(LOCK_LINES);
    localparam logic [X_BITS-1:0] X_MAX   = '1;

    logic              hsync_q, hsync_q2, vsync_q, vsync_q2;
    logic [11:0]       vga_q;
    logic              hs_rise, vs_rise;
    logic              skew_pend;
    logic [1:0]        skew_cnt;
    logic              align, slip, consistent;
    logic              phase;   // 1: the current vga_q word is expected to be the B half
    logic              is_a;
    logic [11:0]       hi;
    logic              asm_vld;
    logic [23:0]       asm_dat;
    logic [X_BITS-1:0] asm_x, x_nxt;
    state_t            state;
    logic [3:0]        lock_cnt;

    // Input stage plus a second sync register for edge detection.
    always_ff @(posedge pixel_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q  <= 1'b0;
            hsync_q2 <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            vga_q    <= 12'd0;
        end else begin
            hsync_q  <= hsync;
            hsync_q2 <= hsync_q;
            vsync_q  <= vsync;
            vsync_q2 <= vsync_q;
            vga_q    <= vga_in;
        end
    end

    assign hs_rise = hsync_q & ~hsync_q2;
    assign vs_rise = vsync_q & ~vsync_q2;

    // SKEW-deep delay from the hsync edge to the word that must be taken as A.
    // A new edge while the delay is pending simply re-arms it.
    always_ff @(posedge pixel_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            skew_pend <= 1'b0;
            skew_cnt  <= 2'd0;
        end else if (hs_rise && SKEW > 0) begin
            skew_pend <= 1'b1;
            skew_cnt  <= SKEW_LD;
        end else if (skew_pend) begin
            if (skew_cnt == 2'd0) skew_pend <= 1'b0;
            else                  skew_cnt  <= skew_cnt - 2'd1;
        end
    end

    always_comb begin
        if (SKEW == 0) align = hs_rise;
        else           align = skew_pend && (skew_cnt == 2'd0) && !hs_rise;
    end

    // Edges are judged at the alignment point against the free-running phase.
    assign slip       = align & phase;
    assign consistent = align & ~phase;
    assign is_a       = align | ~phase;

    // Half assembly and output register stage. An alignment word is always an A,
    // which also drops any A half left waiting from the old phase.
    always_ff @(posedge pixel_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= 1'b0;
            hi          <= 12'd0;
            asm_vld     <= 1'b0;
            asm_dat     <= 24'd0;
            asm_x       <= '0;
            x_nxt       <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= 24'd0;
            x_count     <= '0;
        end else begin
            phase   <= is_a;
            asm_vld <= 1'b0;
            if (is_a) begin
                hi <= vga_q;
                if (align) x_nxt <= '0;
            end else if (locked) begin
                asm_vld <= 1'b1;
                asm_dat <= {hi, vga_q};
                asm_x   <= x_nxt;
                if (x_nxt != X_MAX) x_nxt <= x_nxt + 1'b1;
            end
            pixel_valid <= asm_vld;
            if (asm_vld) begin
                pixel_data <= asm_dat;
                x_count    <= asm_x;
            end
        end
    end

    // Line/frame position; a vsync edge wins over a coincident hsync edge.
    always_ff @(posedge pixel_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            y_count     <= '0;
        end else begin
            frame_start <= vs_rise;
            if (vs_rise)      y_count <= '0;
            else if (hs_rise) y_count <= y_count + 1'b1;
        end
    end

    // Lock tracking. A slip while locked is sticky in phase_err and beats err_clr.
    always_ff @(posedge pixel_clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state     <= UNLOCKED;
            lock_cnt  <= 4'd0;
            locked    <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            if (err_clr) phase_err <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (align) begin
                        lock_cnt <= 4'd1;
                        if (LOCK_N == 4'd1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    if (slip) begin
                        lock_cnt <= 4'd1;
                    end else if (consistent) begin
                        lock_cnt <= lock_cnt + 4'd1;
                        if (lock_cnt + 4'd1 >= LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (slip) begin
                        phase_err <= 1'b1;
                        state     <= LOCKING;
                        lock_cnt  <= 4'd1;
                        locked    <= 1'b0;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_pixel_capture.sv
// Purpose: directed checks of vga_pixel_capture at SKEW=1 (main) plus SKEW=0 and SKEW=3.
// Latency: expectations are timed in 2x-clock cycles from the hsync edge of each line.
// Backpressure: none; the bench streams lines continuously.
module tb_vga_pixel_capture;
    logic        clk = 1'b0;
    logic        reset_n, hsync, vsync, err_clr;
    logic [11:0] vga_in [3];
    logic [23:0] pd [3];
    logic        pv [3];
    logic [9:0]  xc [3];
    logic [9:0]  yc [3];
    logic        fs [3];
    logic        lk [3];
    logic        pe [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Per-line check controls, set before each run_line call.
    bit k_vs, k_mark, k_stream, k_quiet, k_probe;
    bit k_lk_pre, k_lk_post, k_pe_pre, k_pe_post;
    int k_prev, k_yexp, k_clr;

    always #10 clk = ~clk;

    vga_pixel_capture #(.SKEW(1)) u_dut (
        .pixel_clk_2x(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .vga_in(vga_in[0]), .err_clr(err_clr), .pixel_data(pd[0]), .pixel_valid(pv[0]),
        .x_count(xc[0]), .y_count(yc[0]), .frame_start(fs[0]), .locked(lk[0]),
        .phase_err(pe[0])
    );

    vga_pixel_capture #(.SKEW(0)) u_skew0 (
        .pixel_clk_2x(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .vga_in(vga_in[1]), .err_clr(err_clr), .pixel_data(pd[1]), .pixel_valid(pv[1]),
        .x_count(xc[1]), .y_count(yc[1]), .frame_start(fs[1]), .locked(lk[1]),
        .phase_err(pe[1])
    );

    vga_pixel_capture #(.SKEW(3)) u_skew3 (
        .pixel_clk_2x(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .vga_in(vga_in[2]), .err_clr(err_clr), .pixel_data(pd[2]), .pixel_valid(pv[2]),
        .x_count(xc[2]), .y_count(yc[2]), .frame_start(fs[2]), .locked(lk[2]),
        .phase_err(pe[2])
    );

    function automatic int skew_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    // Transmitter: A half on cycles j = skew, skew+2, ... of each line.
    function automatic logic [11:0] word(input int j, input int sk, input bit mark);
        if (mark && j == sk)     return 12'hFFF;
        if (mark && j == sk + 1) return 12'h000;
        return (((j - sk) & 1) == 0) ? 12'hABC : 12'h123;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_knobs();
        k_vs = 0; k_mark = 0; k_stream = 0; k_quiet = 0; k_probe = 0;
        k_lk_pre = 0; k_lk_post = 0; k_pe_pre = 0; k_pe_post = 0;
        k_prev = 0; k_yexp = -1; k_clr = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_data"}, pd[0], 0);
        check({tag, "_pixel_valid"}, pv[0], 0);
        check({tag, "_x_count"}, xc[0], 0);
        check({tag, "_y_count"}, yc[0], 0);
        check({tag, "_frame_start"}, fs[0], 0);
        check({tag, "_locked"}, lk[0], 0);
        check({tag, "_phase_err"}, pe[0], 0);
    endtask

    // Pixel with B driven at cycle j-3 shows up at cycle j; x=0 is the pixel whose
    // A was driven at cycle skew. Cycles before that belong to the previous line.
    task automatic stream_chk(input int i, input int j);
        int sk;
        bit exp_v;
        int exp_x;
        sk = skew_of(i);
        if (j < sk + 4 && k_prev == 0) return;
        exp_v = (((j - sk) & 1) == 0);
        check($sformatf("pixel_valid[%0d] j=%0d", i, j), pv[i], exp_v);
        if (exp_v) begin
            exp_x = (j >= sk + 4) ? (j - sk - 4) / 2 : (j - sk - 4 + k_prev) / 2;
            check($sformatf("x_count[%0d] j=%0d", i, j), xc[i], exp_x);
            check($sformatf("pixel_data[%0d] j=%0d", i, j), pd[i],
                  (k_mark && j == sk + 4) ? 24'hFFF000 : 24'hABC123);
        end
    endtask

    // One line: at each falling edge, check outputs then drive the inputs for cycle j.
    task automatic run_line(input int len, input int hs_len);
        bit any_v;
        any_v = 0;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (k_stream) for (int i = 0; i < 3; i++) stream_chk(i, j);
            any_v |= pv[0];
            if (k_probe && j == skew_of(0) + 1) begin
                check("locked_before_edge", lk[0], k_lk_pre);
                check("phase_err_before_edge", pe[0], k_pe_pre);
            end
            if (k_probe && j == skew_of(0) + 2) begin
                check("locked_after_edge", lk[0], k_lk_post);
                check("phase_err_after_edge", pe[0], k_pe_post);
            end
            if (k_yexp >= 0 && j == 2) begin
                check("y_count", yc[0], k_yexp);
                check("frame_start", fs[0], k_vs);
            end
            if (k_yexp >= 0 && j == 3) check("frame_start_one_cycle", fs[0], 0);
            if (k_clr >= 0 && j == k_clr) check("phase_err_before_clr", pe[0], 1);
            if (k_clr >= 0 && j == k_clr + 1) check("phase_err_after_clr", pe[0], 0);
            hsync   = (j < hs_len);
            vsync   = k_vs && (j < hs_len);
            err_clr = (j == k_clr);
            for (int i = 0; i < 3; i++) vga_in[i] = word(j, skew_of(i), k_mark);
        end
        if (k_quiet) check("no_valid_while_unlocked", any_v, 0);
    endtask

    // Four lines to lock starting from reset; the fourth edge is probed for lock entry.
    task automatic lock_sequence();
        for (int l = 0; l < 3; l++) begin
            clear_knobs(); k_quiet = 1; run_line(800, 96);
        end
        clear_knobs(); k_probe = 1; k_lk_post = 1; k_stream = 1;
        run_line(800, 96);
        clear_knobs(); k_stream = 1; k_prev = 800;
        run_line(800, 96);
    endtask

    initial begin
        reset_n = 0; hsync = 0; vsync = 0; err_clr = 0;
        for (int i = 0; i < 3; i++) vga_in[i] = 12'h000;
        clear_knobs();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;

        // Lock-up over five 800-cycle lines, all three skews.
        lock_sequence();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("locked_after_lockup[%0d]", i), lk[i], 1);
            check($sformatf("no_phase_err_lockup[%0d]", i), pe[i], 0);
        end

        // Marked pixel at the alignment point: 0xFFF000 with x_count=0.
        clear_knobs(); k_stream = 1; k_prev = 800; k_mark = 1;
        run_line(800, 96);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("sweep_locked[%0d]", i), lk[i], 1);
            check($sformatf("sweep_phase_err[%0d]", i), pe[i], 0);
        end

        // Phase slip: one 801-cycle line, then relock over four 800-cycle lines.
        clear_knobs(); k_stream = 1; k_prev = 800;
        run_line(801, 96);
        clear_knobs(); k_probe = 1; k_lk_pre = 1; k_pe_post = 1;
        run_line(800, 96);
        for (int l = 0; l < 2; l++) begin
            clear_knobs(); k_quiet = 1; run_line(800, 96);
        end
        clear_knobs(); k_probe = 1; k_lk_post = 1; k_pe_pre = 1; k_pe_post = 1; k_stream = 1;
        run_line(800, 96);
        check("relocked", lk[0], 1);
        check("phase_err_sticky", pe[0], 1);
        clear_knobs(); k_stream = 1; k_prev = 800; k_clr = 300;
        run_line(800, 96);

        // Frame sync: clear y, count to 524, then vsync coincident with hsync.
        clear_knobs(); k_vs = 1; k_yexp = 0;
        run_line(16, 4);
        clear_knobs();
        for (int l = 0; l < 524; l++) run_line(16, 4);
        check("y_count_524", yc[0], 524);
        clear_knobs(); k_vs = 1; k_yexp = 0;
        run_line(16, 4);
        clear_knobs(); k_yexp = 1;
        run_line(16, 4);

        // Reset while locked and streaming, then relock from scratch.
        clear_knobs(); k_stream = 1; k_prev = 16;
        run_line(800, 96);
        #2 reset_n = 0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        reset_n = 1;
        lock_sequence();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
